// File: rtl/ntt_output_serializer_if.sv
// Downstream coefficient stream of the NTT output serializer; m_index exists only
// when NTT_SER_INDEX_EN is defined.
interface ntt_output_serializer_if #(
  parameter int COEFF_WIDTH = 30
);
  logic [COEFF_WIDTH-1:0] m_data;
  logic                   m_valid;
  logic                   m_ready;
  logic                   m_last;
`ifdef NTT_SER_INDEX_EN
  logic [10:0]            m_index;

  modport master (
    output m_data, m_valid, m_last, m_index,
    input  m_ready
  );

  modport slave (
    input  m_data, m_valid, m_last, m_index,
    output m_ready
  );
`else
  modport master (
    output m_data, m_valid, m_last,
    input  m_ready
  );

  modport slave (
    input  m_data, m_valid, m_last,
    output m_ready
  );
`endif
endinterface

// File: rtl/ntt_output_serializer.sv
// Buffers parallel NTT result beats and emits them one coefficient per transfer.
// Optional macro NTT_SER_INDEX_EN adds the m_index coefficient-index output.
module ntt_output_serializer #(
  parameter int LOG_CORE_COUNT = 4,
  parameter int COEFF_WIDTH    = 30,
  parameter int LOG_BEAT_DEPTH = 2
) (
  input  logic                                                  clk,
  input  logic                                                  rst,
  input  logic                                                  output_active,
  input  logic [(1<<LOG_CORE_COUNT)-1:0][1:0][2*COEFF_WIDTH-1:0] out,
  ntt_output_serializer_if.master                               m,
  output logic                                                  overflow,
  output logic                                                  busy
);

  localparam int CORES     = 1 << LOG_CORE_COUNT;
  localparam int LOG_LANES = LOG_CORE_COUNT + 2;
  localparam int LANES     = 1 << LOG_LANES;
  localparam int DEPTH     = 1 << LOG_BEAT_DEPTH;
  localparam int IDX_W     = 11;
  localparam int TAG_W     = IDX_W - LOG_LANES;
  localparam int BEAT_W    = CORES * 4 * COEFF_WIDTH;
  localparam int OCC_W     = LOG_BEAT_DEPTH + 1;

  typedef logic [LOG_LANES-1:0]      lane_t;
  typedef logic [TAG_W-1:0]          tag_t;
  typedef logic [LOG_BEAT_DEPTH-1:0] ptr_t;
  typedef logic [OCC_W-1:0]          occ_t;

  localparam lane_t LANE_LAST = lane_t'(LANES - 1);
  localparam tag_t  TAG_LAST  = tag_t'((1 << TAG_W) - 1);
  localparam occ_t  OCC_FULL  = occ_t'(DEPTH);

  // Packed word order already places lane l at bits [l*COEFF_WIDTH +: COEFF_WIDTH].
  logic [BEAT_W-1:0] beat_mem [DEPTH];
  tag_t              tag_mem  [DEPTH];

  ptr_t  wr_ptr;
  ptr_t  rd_ptr;
  occ_t  occ;
  occ_t  occ_nxt;
  lane_t lane;
  tag_t  beat_cnt;

  logic  buf_full;
  logic  head_vld;
  logic  xfer;
  logic  retire;
  logic  accept;
  logic  drop;
  tag_t  head_tag;

  assign buf_full = (occ == OCC_FULL);
  assign head_vld = (occ != '0);
  assign xfer     = head_vld & m.m_ready;
  assign retire   = xfer & (lane == LANE_LAST);
  // A beat landing on the retire cycle takes the slot being freed.
  assign accept   = output_active & (~buf_full | retire);
  assign drop     = output_active & buf_full & ~retire;
  assign head_tag = tag_mem[rd_ptr];

  always_comb begin
    occ_nxt = occ;
    case ({accept, retire})
      2'b10:   occ_nxt = occ + occ_t'(1);
      2'b01:   occ_nxt = occ - occ_t'(1);
      default: occ_nxt = occ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      occ      <= '0;
      lane     <= '0;
      beat_cnt <= '0;
      overflow <= 1'b0;
    end else begin
      occ <= occ_nxt;
      if (output_active) begin
        beat_cnt <= beat_cnt + tag_t'(1);
      end
      if (accept) begin
        wr_ptr <= wr_ptr + ptr_t'(1);
      end
      if (drop) begin
        overflow <= 1'b1;
      end
      if (xfer) begin
        lane <= (lane == LANE_LAST) ? '0 : lane + lane_t'(1);
      end
      if (retire) begin
        rd_ptr <= rd_ptr + ptr_t'(1);
      end
    end
  end

  // Beat storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (!rst && accept) begin
      beat_mem[wr_ptr] <= out;
      tag_mem[wr_ptr]  <= beat_cnt;
    end
  end

  always_comb begin
    m.m_valid = head_vld;
    m.m_data  = beat_mem[rd_ptr][lane*COEFF_WIDTH +: COEFF_WIDTH];
    m.m_last  = head_vld & (head_tag == TAG_LAST) & (lane == LANE_LAST);
  end

`ifdef NTT_SER_INDEX_EN
  always_comb begin
    m.m_index = '0;
    if (head_vld) begin
      m.m_index = {head_tag, lane};
    end
  end
`endif

  assign busy = head_vld;

endmodule

// File: tb/tb_ntt_output_serializer.sv
// Scoreboard bench for ntt_output_serializer: beats are expanded into expected
// coefficients when driven and compared as the serializer transfers them.
`timescale 1ns/1ps
module tb_ntt_output_serializer;
  localparam int LCC   = 4;
  localparam int CW    = 30;
  localparam int LBD   = 2;
  localparam int CORES = 16;
  localparam int LANES = 64;

  typedef struct {
    logic [CW-1:0] data;
    logic [10:0]   idx;
    logic          last;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic output_active;
  logic [CORES-1:0][1:0][2*CW-1:0] out_w;
  logic overflow;
  logic busy;

  int   total = 0;
  int   bad   = 0;
  int   last_seen = 0;
  int   tb_tag = 0;
  exp_t exp_q[$];
  exp_t mon_e;

  ntt_output_serializer_if #(.COEFF_WIDTH(CW)) sif ();

  ntt_output_serializer #(
    .LOG_CORE_COUNT(LCC),
    .COEFF_WIDTH(CW),
    .LOG_BEAT_DEPTH(LBD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .output_active(output_active),
    .out(out_w),
    .m(sif),
    .overflow(overflow),
    .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, required finish");
    $fatal(1);
  end

  always @(negedge clk) begin
    if (!rst && sif.m_valid && sif.m_ready) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_xfer: got data=%0h, required no transfer", sif.m_data);
      end else begin
        mon_e = exp_q.pop_front();
        total++;
        if (sif.m_data !== mon_e.data) begin
          bad++;
          $display("FAIL xfer_data idx=%0d: got %0h, required %0h", mon_e.idx, sif.m_data, mon_e.data);
        end
        total++;
        if (sif.m_last !== mon_e.last) begin
          bad++;
          $display("FAIL xfer_last idx=%0d: got %b, required %b", mon_e.idx, sif.m_last, mon_e.last);
        end
`ifdef NTT_SER_INDEX_EN
        total++;
        if (sif.m_index !== mon_e.idx) begin
          bad++;
          $display("FAIL xfer_index: got %0d, required %0d", sif.m_index, mon_e.idx);
        end
`endif
      end
      if (sif.m_last === 1'b1) last_seen++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_random();
    for (int i = 0; i < CORES; i++)
      for (int j = 0; j < 2; j++)
        out_w[i][j] = {CW'($urandom), CW'($urandom)};
  endtask

  // Drives the current out_w for one cycle; a kept beat is expanded lane by lane.
  task automatic send_current(input bit keep);
    logic [2*CW-1:0] w;
    exp_t e;
    if (keep) begin
      for (int l = 0; l < LANES; l++) begin
        w = out_w[l/4][(l/2)%2];
        e.data = (l % 2 == 1) ? w[2*CW-1:CW] : w[CW-1:0];
        e.idx  = 11'(tb_tag * LANES + l);
        e.last = (e.idx == 11'd2047);
        exp_q.push_back(e);
      end
    end
    output_active = 1'b1;
    tick();
    output_active = 1'b0;
    tb_tag = (tb_tag + 1) % 32;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    output_active = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    output_active = 1'b0;
    exp_q.delete();
    tb_tag = 0;
  endtask

  task automatic wait_drain(input int bound, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < bound; c++) begin
      if (exp_q.size() == 0 && busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (exp_q.size() == 0 && busy === 1'b0) ok = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    output_active = 1'b1;
    sif.m_ready = 1'b1;
    fill_random();
    for (int c = 0; c < 3; c++) begin
      tick();
      total++;
      if (sif.m_valid !== 1'b0 || sif.m_last !== 1'b0) begin
        bad++;
        $display("FAIL reset_valid_last: got valid=%b last=%b, required 0 0", sif.m_valid, sif.m_last);
      end
      total++;
      if (busy !== 1'b0 || overflow !== 1'b0) begin
        bad++;
        $display("FAIL reset_busy_ovf: got busy=%b overflow=%b, required 0 0", busy, overflow);
      end
`ifdef NTT_SER_INDEX_EN
      total++;
      if (sif.m_index !== 11'd0) begin
        bad++;
        $display("FAIL reset_index: got %0d, required 0", sif.m_index);
      end
`endif
    end
    rst = 1'b0;
    output_active = 1'b0;
    exp_q.delete();
    tb_tag = 0;
  endtask

  task automatic test_single_beat();
    bit ok;
    do_reset();
    sif.m_ready = 1'b1;
    fill_random();
    out_w[0][0] = {30'd2, 30'd1};
    send_current(1'b1);
    total++;
    if (sif.m_valid !== 1'b1 || sif.m_data !== 30'd1) begin
      bad++;
      $display("FAIL single_latency: got valid=%b data=%0d, required 1 1", sif.m_valid, sif.m_data);
    end
    tick();
    total++;
    if (sif.m_data !== 30'd2) begin
      bad++;
      $display("FAIL single_lane1: got %0d, required 2", sif.m_data);
    end
    wait_drain(200, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL single_drain: got %0d pending, required 0", exp_q.size());
    end
  endtask

  task automatic test_full_transform();
    bit ok;
    int last0;
    do_reset();
    sif.m_ready = 1'b1;
    last0 = last_seen;
    for (int b = 0; b < 32; b++) begin
      fill_random();
      send_current(1'b1);
      repeat (63) tick();
    end
    wait_drain(400, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL transform_drain: got %0d pending, required 0", exp_q.size());
    end
    total++;
    if (last_seen - last0 != 1) begin
      bad++;
      $display("FAIL transform_last_count: got %0d, required 1", last_seen - last0);
    end
    total++;
    if (overflow !== 1'b0) begin
      bad++;
      $display("FAIL transform_overflow: got %b, required 0", overflow);
    end
  endtask

  task automatic test_stall();
    bit ok;
    logic [CW-1:0] hold_d;
    do_reset();
    sif.m_ready = 1'b1;
    fill_random();
    send_current(1'b1);
    repeat (9) tick();
    sif.m_ready = 1'b0;
    hold_d = sif.m_data;
    for (int c = 0; c < 20; c++) begin
      tick();
      total++;
      if (sif.m_valid !== 1'b1 || sif.m_data !== hold_d) begin
        bad++;
        $display("FAIL stall_hold c=%0d: got valid=%b data=%0h, required 1 %0h", c, sif.m_valid, sif.m_data, hold_d);
      end
    end
    sif.m_ready = 1'b1;
    wait_drain(200, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL stall_drain: got %0d pending, required 0", exp_q.size());
    end
  endtask

  task automatic test_overflow();
    bit ok;
    do_reset();
    sif.m_ready = 1'b0;
    for (int b = 0; b < 5; b++) begin
      fill_random();
      send_current(b < 4);
    end
    total++;
    if (overflow !== 1'b1 || busy !== 1'b1) begin
      bad++;
      $display("FAIL ovf_set: got overflow=%b busy=%b, required 1 1", overflow, busy);
    end
    sif.m_ready = 1'b1;
    wait_drain(400, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL ovf_drain: got %0d pending, required 0", exp_q.size());
    end
    total++;
    if (overflow !== 1'b1) begin
      bad++;
      $display("FAIL ovf_sticky: got %b, required 1", overflow);
    end
    fill_random();
    send_current(1'b1);
`ifdef NTT_SER_INDEX_EN
    total++;
    if (sif.m_index !== 11'd320) begin
      bad++;
      $display("FAIL ovf_next_index: got %0d, required 320", sif.m_index);
    end
`endif
    wait_drain(200, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL ovf_next_drain: got %0d pending, required 0", exp_q.size());
    end
  endtask

  task automatic test_full_retire();
    bit ok;
    do_reset();
    sif.m_ready = 1'b0;
    for (int b = 0; b < 4; b++) begin
      fill_random();
      send_current(1'b1);
    end
    sif.m_ready = 1'b1;
    repeat (63) tick();
    fill_random();
    send_current(1'b1);
    total++;
    if (overflow !== 1'b0) begin
      bad++;
      $display("FAIL retire_accept_ovf: got %b, required 0", overflow);
    end
    wait_drain(600, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL retire_drain: got %0d pending, required 0", exp_q.size());
    end
    total++;
    if (overflow !== 1'b0) begin
      bad++;
      $display("FAIL retire_final_ovf: got %b, required 0", overflow);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    do_reset();
    sif.m_ready = 1'b1;
    for (int b = 0; b < 10; b++) begin
      fill_random();
      send_current(1'b1);
      repeat ((b == 9) ? 20 : 63) tick();
    end
    rst = 1'b1;
    tick();
    total++;
    if (sif.m_valid !== 1'b0 || busy !== 1'b0 || overflow !== 1'b0) begin
      bad++;
      $display("FAIL midreset_state: got valid=%b busy=%b overflow=%b, required 0 0 0", sif.m_valid, busy, overflow);
    end
    rst = 1'b0;
    exp_q.delete();
    tb_tag = 0;
    fill_random();
    send_current(1'b1);
`ifdef NTT_SER_INDEX_EN
    total++;
    if (sif.m_index !== 11'd0) begin
      bad++;
      $display("FAIL midreset_index: got %0d, required 0", sif.m_index);
    end
`endif
    wait_drain(200, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL midreset_drain: got %0d pending, required 0", exp_q.size());
    end
  endtask

  initial begin
    rst = 1'b1;
    output_active = 1'b0;
    sif.m_ready = 1'b0;
    out_w = '0;
    test_reset();
    test_single_beat();
    test_full_transform();
    test_stall();
    test_overflow();
    test_full_retire();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
